// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit sampling FSM and a
// single-entry valid/ready output buffer with framing-error and overrun pulses.
module uart_rx #(
  parameter int FREQ = 27_000_000,
  parameter int BAUD = 115_200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  // state   | meaning
  // IDLE    | line idle, waiting for a low rx_s
  // START   | qualifying the start bit at half a bit time
  // DATA    | sampling 8 data bits, LSB first, at mid-bit
  // STOP    | sampling the stop bit
  // WAIT_HI | bad stop / break: wait for the line to return high

  localparam int CLKS_PER_BIT = FREQ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  if (CLKS_PER_BIT < 4) begin : g_baud_check
    $error("uart_rx: FREQ/BAUD must be at least 4");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          deliver;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s_q, shreg_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = IDLE;
            deliver = 1'b1;
          end else begin
            state_d     = WAIT_HI;
            frame_err_d = 1'b1;
          end
        end
      end
      WAIT_HI: begin
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A consumer draining on the same edge frees the slot for the new byte.
    if (deliver) begin
      if (!valid_q || ready_i) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit: table-driven frames plus
// hand-written sequences for glitch, break, overrun and mid-frame reset.
module tb_uart_rx;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       rx_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i = 1'b1;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] acc_q[$];
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         stab_err = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  uart_rx #(.FREQ(1_000_000), .BAUD(100_000)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (valid_o && ready_i) acc_q.push_back(data_o);
      if (frame_err_o) ferr_cnt++;
      if (overrun_o) ovr_cnt++;
      if (prev_hold && valid_o && !ready_i && data_o != prev_data) stab_err++;
      prev_hold = valid_o && !ready_i;
      prev_data = data_o;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx_i = b;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_len);
    drive_bit(1'b0, 10);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 10);
    drive_bit(stop_val, stop_len);
  endtask

  task automatic clear_mon();
    acc_q.delete();
    ferr_cnt = 0;
    ovr_cnt  = 0;
    stab_err = 0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_n;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
    vecs[3] = '{8'h81, 1'b1, 1, 8'h81, 0};
    vecs[4] = '{8'h7E, 1'b0, 0, 8'h00, 1};
    vecs[5] = '{8'h3C, 1'b1, 1, 8'h3C, 0};

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset valid", valid_o, 0);
    chk("reset data", data_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset ferr", frame_err_o, 0);
    chk("reset ovr", overrun_o, 0);
    @(posedge clk_i); #1;

    for (int v = 0; v < 6; v++) begin
      clear_mon();
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].stop ? 10 : 30);
      drive_bit(1'b1, 25);
      chk($sformatf("vec%0d count", v), acc_q.size(), vecs[v].exp_n);
      if (vecs[v].exp_n > 0 && acc_q.size() > 0)
        chk($sformatf("vec%0d data", v), acc_q[0], vecs[v].exp_data);
      chk($sformatf("vec%0d ferr", v), ferr_cnt, vecs[v].exp_ferr);
      chk($sformatf("vec%0d ovr", v), ovr_cnt, 0);
      chk($sformatf("vec%0d busy", v), busy_o, 0);
    end

    // back-to-back frames, no idle gap
    clear_mon();
    send_frame(8'h00, 1'b1, 10);
    send_frame(8'hFF, 1'b1, 10);
    drive_bit(1'b1, 25);
    chk("b2b count", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("b2b first", acc_q[0], 8'h00);
      chk("b2b second", acc_q[1], 8'hFF);
    end
    chk("b2b ferr", ferr_cnt, 0);

    // 3-cycle glitch
    clear_mon();
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 30);
    chk("glitch count", acc_q.size(), 0);
    chk("glitch ferr", ferr_cnt, 0);
    chk("glitch busy", busy_o, 0);

    // stop bit low, line held low as a break, then recovery
    clear_mon();
    send_frame(8'h3C, 1'b0, 50);
    chk("break busy", busy_o, 1);
    drive_bit(1'b1, 20);
    chk("break ferr", ferr_cnt, 1);
    chk("break count", acc_q.size(), 0);
    send_frame(8'h12, 1'b1, 10);
    drive_bit(1'b1, 20);
    chk("after break count", acc_q.size(), 1);
    if (acc_q.size() > 0) chk("after break data", acc_q[0], 8'h12);
    chk("after break ferr", ferr_cnt, 1);

    // overrun with consumer stalled
    clear_mon();
    ready_i = 1'b0;
    send_frame(8'h11, 1'b1, 10);
    send_frame(8'h22, 1'b1, 10);
    drive_bit(1'b1, 20);
    chk("ovr valid held", valid_o, 1);
    chk("ovr data held", data_o, 8'h11);
    chk("ovr pulses", ovr_cnt, 1);
    chk("ovr ferr", ferr_cnt, 0);
    chk("ovr stable", stab_err, 0);
    ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("ovr drain valid", valid_o, 0);
    chk("ovr drain count", acc_q.size(), 1);
    if (acc_q.size() > 0) chk("ovr drain data", acc_q[0], 8'h11);
    @(posedge clk_i); #1;

    // reset in the middle of DATA
    clear_mon();
    drive_bit(1'b0, 10);
    drive_bit(1'b1, 10);
    drive_bit(1'b0, 10);
    drive_bit(1'b1, 10);
    chk("pre-reset busy", busy_o, 1);
    rst_i = 1'b1;
    rx_i  = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("mid reset busy", busy_o, 0);
    chk("mid reset data", data_o, 0);
    chk("mid reset valid", valid_o, 0);
    chk("mid reset ferr", frame_err_o, 0);
    @(posedge clk_i); #1;
    drive_bit(1'b1, 30);
    clear_mon();
    send_frame(8'h66, 1'b1, 10);
    drive_bit(1'b1, 20);
    chk("post reset count", acc_q.size(), 1);
    if (acc_q.size() > 0) chk("post reset data", acc_q[0], 8'h66);
    chk("post reset ferr", ferr_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
